inst_loader: RTL and testbench

- Writer side of the CPU instruction memory; the fetch path only reads it.
- Accepts a byte stream with valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the CPU stopped (o_cpu_stop drives the CPU stop input) for the whole load, then releases it.

---
 rtl/inst_loader_if.sv | 30 +++
 rtl/inst_loader.sv | 72 +++++++
 tb/tb_inst_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream, control and instruction-memory write bundle for inst_loader
// master: drives start/length/abort and the byte stream, observes memory writes and status
// slave:  the loader; accepts bytes and control, drives memory writes, cpu stop and status
interface inst_loader_if #(
  parameter int ADDR_W = 12,
  parameter int INST_W = 16,
  parameter int BYTE_W = 8
);
  logic              i_start;
  logic [ADDR_W-1:0] i_length;
  logic              i_abort;
  logic              i_byte_valid;
  logic [BYTE_W-1:0] i_byte_data;
  logic              o_byte_ready;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [INST_W-1:0] o_mem_wdata;
  logic              o_cpu_stop;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W-1:0] o_count;
  modport master (
    output i_start, i_length, i_abort, i_byte_valid, i_byte_data,
    input  o_byte_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_stop, o_busy, o_done, o_count
  );
  modport slave (
    input  i_start, i_length, i_abort, i_byte_valid, i_byte_data,
    output o_byte_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_stop, o_busy, o_done, o_count
  );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: assembles a high-byte-first byte stream into instruction words and writes them from address 0
// i_clk: clock; i_reset: synchronous active-low reset
// bus (slave): i_start/i_length/i_abort control, i_byte_valid/i_byte_data/o_byte_ready stream,
//              o_mem_we/o_mem_addr/o_mem_wdata memory write, o_cpu_stop/o_busy/o_done/o_count status
module inst_loader #(
  parameter int ADDR_W = 12,
  parameter int INST_W = 16,
  parameter int BYTE_W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  inst_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;
  state_t            state, state_n;
  logic [BYTE_W-1:0] hi;
  logic [ADDR_W-1:0] len;
  logic              hs, last, we_n, stop_n, done_n;
  always_ff @(posedge i_clk)
    state <= !i_reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !bus.i_start ? IDLE : bus.i_length == '0 ? DONE : HI;
      HI:      state_n = bus.i_abort ? IDLE : hs ? LO : HI;
      LO:      state_n = bus.i_abort ? IDLE : hs ? WRITE : LO;
      WRITE:   state_n = bus.i_abort ? IDLE : last ? DONE : HI;
      default: state_n = IDLE;
    endcase
  end
  // Registered outputs are loaded from the next state so they are valid in the state they describe.
  always_comb begin
    bus.o_byte_ready = state == HI || state == LO;
    hs               = bus.o_byte_ready && bus.i_byte_valid;
    last             = bus.o_count + ADDR_W'(1) == len;
    we_n             = state_n == WRITE;
    stop_n           = state_n == HI || state_n == LO || state_n == WRITE;
    done_n           = state_n == DONE;
  end
  // o_count doubles as the write address counter; both advance together when WRITE is left,
  // including on abort, because the write in that cycle still lands.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      bus.o_mem_we    <= 1'b0;
      bus.o_cpu_stop  <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      bus.o_count     <= '0;
      hi              <= '0;
      len             <= '0;
    end else begin
      bus.o_mem_we   <= we_n;
      bus.o_cpu_stop <= stop_n;
      bus.o_busy     <= stop_n;
      bus.o_done     <= done_n;
      if (state == IDLE && bus.i_start) begin
        len         <= bus.i_length;
        bus.o_count <= '0;
      end
      if (state == HI && hs)
        hi <= bus.i_byte_data;
      if (state == LO && hs && !bus.i_abort) begin
        bus.o_mem_wdata <= INST_W'({hi, bus.i_byte_data});
        bus.o_mem_addr  <= bus.o_count;
      end
      if (state == WRITE)
        bus.o_count <= bus.o_count + ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: scoreboard bench for inst_loader covering reset, streaming, stalls, zero length, abort and restart
module tb_inst_loader;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  inst_loader_if #(.ADDR_W(12), .INST_W(16), .BYTE_W(8)) bus ();
  inst_loader #(.ADDR_W(12), .INST_W(16), .BYTE_W(8)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));
  always #5 i_clk = ~i_clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [27:0] exp_q[$];
  logic [7:0]  byte_q[$];
  int          we_cyc[$];
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic push_word(input logic [11:0] addr, input logic [7:0] h, input logic [7:0] l);
    exp_q.push_back({addr, h, l});
    byte_q.push_back(h);
    byte_q.push_back(l);
  endtask
  task automatic begin_load(input logic [11:0] len);
    bus.i_start = 1'b1;
    bus.i_length = len;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
  endtask
  task automatic feed(input bit gap, input bit do_abort, input bit poke);
    int n;
    while (byte_q.size() > 0) begin
      if (gap) begin
        bus.i_byte_valid = 1'b0;
        @(posedge i_clk); #1;
      end
      bus.i_byte_valid = 1'b1;
      bus.i_byte_data = byte_q.pop_front();
      if (poke) begin
        bus.i_start = 1'b1;
        bus.i_length = 12'd7;
      end
      n = 0;
      @(negedge i_clk);
      while (!bus.o_byte_ready && n < 20) begin
        @(negedge i_clk);
        n++;
      end
      @(posedge i_clk); #1;
      bus.i_start = 1'b0;
      poke = 1'b0;
    end
    bus.i_byte_valid = 1'b0;
    if (do_abort) begin
      bus.i_abort = 1'b1;
      @(posedge i_clk); #1;
      bus.i_abort = 1'b0;
    end
  endtask
  task automatic watch(input int budget, output int stop_cnt, output bit to);
    bit seen;
    logic [27:0] e;
    seen = 1'b0;
    stop_cnt = 0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (bus.o_mem_we) begin
        we_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got %h:%h, no write expected", bus.o_mem_addr, bus.o_mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_mem_addr, bus.o_mem_wdata} !== e) begin
            errors++;
            $display("FAIL write_data: got %h:%h, expected %h:%h", bus.o_mem_addr, bus.o_mem_wdata, e[27:16], e[15:0]);
          end
        end
        checks++;
        if (bus.o_byte_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_write: got %b, expected 0", bus.o_byte_ready);
        end
      end
      if (bus.o_cpu_stop) stop_cnt++;
      if (bus.o_done) done_cnt++;
      if (bus.o_busy) seen = 1'b1;
      if (bus.o_done || (seen && !bus.o_busy)) begin
        to = 1'b0;
        break;
      end
    end
  endtask
  task automatic test_reset();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++;
    if ({bus.o_byte_ready, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_cpu_stop, bus.o_busy, bus.o_done, bus.o_count} !== 45'd0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (stop=%b busy=%b we=%b count=%h)", bus.o_cpu_stop, bus.o_busy, bus.o_mem_we, bus.o_count);
    end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    begin_load(12'd3);
    bus.i_byte_valid = 1'b1;
    bus.i_byte_data = 8'h11;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    checks++;
    if ({bus.o_mem_we, bus.o_cpu_stop} !== 2'b11) begin
      errors++;
      $display("FAIL reset_midload_setup: got we,stop=%b%b, expected 11", bus.o_mem_we, bus.o_cpu_stop);
    end
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if ({bus.o_byte_ready, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_cpu_stop, bus.o_busy, bus.o_done, bus.o_count} !== 45'd0) begin
      errors++;
      $display("FAIL reset_midload: outputs not all zero (stop=%b busy=%b we=%b wdata=%h)", bus.o_cpu_stop, bus.o_busy, bus.o_mem_we, bus.o_mem_wdata);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    bus.i_byte_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({bus.o_byte_ready, bus.o_cpu_stop, bus.o_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle: got ready,stop,busy=%b%b%b, expected 000", bus.o_byte_ready, bus.o_cpu_stop, bus.o_busy);
    end
  endtask
  task automatic test_back_to_back();
    int sc;
    bit to;
    we_cyc.delete();
    done_cnt = 0;
    push_word(12'd0, 8'h12, 8'h34);
    push_word(12'd1, 8'h56, 8'h78);
    push_word(12'd2, 8'h9A, 8'hBC);
    begin_load(12'd3);
    checks++;
    if ({bus.o_cpu_stop, bus.o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_stop_rise: got stop,busy=%b%b, expected 11", bus.o_cpu_stop, bus.o_busy);
    end
    fork
      feed(1'b0, 1'b0, 1'b0);
      watch(100, sc, to);
    join
    checks++;
    if (to !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL b2b_done: timeout=%b done pulses=%0d, expected 0 and 1", to, done_cnt);
    end
    checks++;
    if ({bus.o_cpu_stop, bus.o_busy, bus.o_count} !== {2'b00, 12'd3}) begin
      errors++;
      $display("FAIL b2b_done_state: got stop=%b busy=%b count=%0d, expected 0 0 3", bus.o_cpu_stop, bus.o_busy, bus.o_count);
    end
    checks++;
    if (sc != 9) begin
      errors++;
      $display("FAIL b2b_stop_span: got %0d stop cycles, expected 9", sc);
    end
    checks++;
    if (we_cyc.size() != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_write_count: got %0d writes, %0d still expected", we_cyc.size(), exp_q.size());
    end else begin
      checks++;
      if (we_cyc[1] - we_cyc[0] != 3 || we_cyc[2] - we_cyc[1] != 3) begin
        errors++;
        $display("FAIL b2b_spacing: got gaps %0d,%0d, expected 3,3", we_cyc[1] - we_cyc[0], we_cyc[2] - we_cyc[1]);
      end
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_width: got o_done=%b one cycle later, expected 0", bus.o_done);
    end
  endtask
  task automatic test_toggle();
    int sc;
    bit to;
    we_cyc.delete();
    done_cnt = 0;
    push_word(12'd0, 8'hA1, 8'hB2);
    push_word(12'd1, 8'hC3, 8'hD4);
    begin_load(12'd2);
    fork
      feed(1'b1, 1'b0, 1'b0);
      watch(100, sc, to);
    join
    checks++;
    if (to !== 1'b0 || done_cnt != 1 || bus.o_count !== 12'd2) begin
      errors++;
      $display("FAIL toggle_done: timeout=%b done=%0d count=%0d, expected 0 1 2", to, done_cnt, bus.o_count);
    end
    checks++;
    if (we_cyc.size() != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_writes: got %0d writes, %0d still expected", we_cyc.size(), exp_q.size());
    end
    @(negedge i_clk);
  endtask
  task automatic test_zero();
    begin_load(12'd0);
    @(negedge i_clk);
    checks++;
    if ({bus.o_done, bus.o_cpu_stop, bus.o_mem_we, bus.o_busy} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_done: got done,stop,we,busy=%b%b%b%b, expected 1000", bus.o_done, bus.o_cpu_stop, bus.o_mem_we, bus.o_busy);
    end
    @(negedge i_clk);
    checks++;
    if ({bus.o_done, bus.o_cpu_stop, bus.o_mem_we, bus.o_busy, bus.o_byte_ready, bus.o_count} !== 17'd0) begin
      errors++;
      $display("FAIL zero_idle: got done,stop,we,busy,ready=%b%b%b%b%b count=%0d, expected all 0", bus.o_done, bus.o_cpu_stop, bus.o_mem_we, bus.o_busy, bus.o_byte_ready, bus.o_count);
    end
  endtask
  task automatic test_abort();
    int sc;
    bit to;
    bit extra_we;
    we_cyc.delete();
    done_cnt = 0;
    push_word(12'd0, 8'h01, 8'h02);
    push_word(12'd1, 8'h03, 8'h04);
    byte_q.push_back(8'h05);
    begin_load(12'd4);
    fork
      feed(1'b0, 1'b1, 1'b0);
      watch(100, sc, to);
    join
    checks++;
    if (to !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_end: timeout=%b done=%0d, expected 0 0", to, done_cnt);
    end
    checks++;
    if ({bus.o_cpu_stop, bus.o_busy, bus.o_count} !== {2'b00, 12'd2}) begin
      errors++;
      $display("FAIL abort_state: got stop=%b busy=%b count=%0d, expected 0 0 2", bus.o_cpu_stop, bus.o_busy, bus.o_count);
    end
    checks++;
    if (sc != 8 || we_cyc.size() != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_writes: got stop cycles=%0d writes=%0d pending=%0d, expected 8 2 0", sc, we_cyc.size(), exp_q.size());
    end
    extra_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (bus.o_mem_we || bus.o_done) extra_we = 1'b1;
    end
    checks++;
    if (extra_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got late write or done=%b, expected 0", extra_we);
    end
  endtask
  task automatic test_restart();
    int sc;
    bit to;
    we_cyc.delete();
    done_cnt = 0;
    push_word(12'd0, 8'hDE, 8'hAD);
    push_word(12'd1, 8'hBE, 8'hEF);
    begin_load(12'd2);
    fork
      feed(1'b0, 1'b0, 1'b1);
      watch(100, sc, to);
    join
    checks++;
    if (to !== 1'b0 || done_cnt != 1 || bus.o_count !== 12'd2 || sc != 6) begin
      errors++;
      $display("FAIL restart_ignored: timeout=%b done=%0d count=%0d stop cycles=%0d, expected 0 1 2 6", to, done_cnt, bus.o_count, sc);
    end
    @(negedge i_clk);
    push_word(12'd0, 8'hCA, 8'hFE);
    begin_load(12'd1);
    fork
      feed(1'b0, 1'b0, 1'b0);
      watch(100, sc, to);
    join
    checks++;
    if (to !== 1'b0 || done_cnt != 2 || bus.o_count !== 12'd1 || exp_q.size() != 0 || we_cyc.size() != 3) begin
      errors++;
      $display("FAIL restart_fresh: timeout=%b done=%0d count=%0d pending=%0d writes=%0d, expected 0 2 1 0 3", to, done_cnt, bus.o_count, exp_q.size(), we_cyc.size());
    end
    @(negedge i_clk);
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_length = '0;
    bus.i_abort = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_data = '0;
    test_reset();
    test_back_to_back();
    test_toggle();
    test_zero();
    test_abort();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
